// File: rtl/neighbor_id_fetch.sv
// Pops neighbour-list descriptors from the Neighbor ID FIFO, streams the IDs out of the
// edge-list SRAM and hands them to the Edge PE dispatch through a credit-guarded buffer.
module neighbor_id_fetch #(
  parameter int PTR_W     = 12,
  parameter int CNT_W     = 5,
  parameter int ID_W      = 16,
  parameter int TAG_W     = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [PTR_W+CNT_W-1:0] fifo_desc,
  input  logic [TAG_W-1:0]       fifo_tag,
  output logic                   fifo_rinc,
  output logic [PTR_W-1:0]       sram_A,
  output logic                   sram_CEN,
  input  logic [ID_W-1:0]        sram_Q,
  output logic                   out_valid,
  output logic [ID_W-1:0]        out_id,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = ID_W + TAG_W + 1;
  localparam logic [CW:0]       DEPTH_L = BUF_DEPTH;
  localparam logic [AW-1:0]     LAST_SLOT = AW'(BUF_DEPTH - 1);
  localparam logic [AW-1:0]     PTR_ONE_B = 1;
  localparam logic [CW-1:0]     OCC_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE = 1;
  localparam logic [PTR_W-1:0]  ADDR_ONE = 1;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [PTR_W-1:0]  sram_a_q, sram_a_d;
  logic              sram_cen_q, sram_cen_d;
  logic              last1_q, last1_d;
  logic              rd2_q, rd2_d;
  logic              last2_q, last2_d;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [EW-1:0]     buf_q [BUF_DEPTH];

  logic [PTR_W-1:0]  fifo_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              rd1;
  logic [1:0]        inflight;
  logic [CW:0]       credit_sum;
  logic              credit_ok;
  logic              issue, issue_last;
  logic [PTR_W-1:0]  issue_addr;
  logic              push, pop;
  logic [EW-1:0]     head;

  assign fifo_ptr   = fifo_desc[PTR_W+CNT_W-1 -: PTR_W];
  assign fifo_cnt   = fifo_desc[CNT_W-1:0];
  assign rd1        = !sram_cen_q;
  assign inflight   = {1'b0, rd1} + {1'b0, rd2_q};
  assign credit_sum = {1'b0, occ_q} + {{(CW-1){1'b0}}, inflight};
  // Reserve a slot for every read already in the SRAM pipe, so back-pressure never drops a word.
  assign credit_ok  = credit_sum < DEPTH_L;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      tag_q      <= '0;
      sram_a_q   <= '0;
      sram_cen_q <= 1'b1;
      last1_q    <= 1'b0;
      rd2_q      <= 1'b0;
      last2_q    <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      tag_q      <= tag_d;
      sram_a_q   <= sram_a_d;
      sram_cen_q <= sram_cen_d;
      last1_q    <= last1_d;
      rd2_q      <= rd2_d;
      last2_q    <= last2_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_q] <= {last2_q, tag_q, sram_Q};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifo_rinc && (fifo_cnt != '0)) begin
          state_d = (fifo_cnt == CNT_ONE) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (issue && issue_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ_d == '0) && !rd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The first read is issued in the pop cycle itself so A=ptr appears one cycle after the pop.
  always_comb begin
    fifo_rinc  = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = addr_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tag_d      = tag_q;
    case (state_q)
      IDLE: begin
        fifo_rinc = !fifo_empty && (occ_q == '0) && (inflight == 2'd0);
        if (fifo_rinc) begin
          tag_d = fifo_tag;
          if (fifo_cnt != '0) begin
            issue      = 1'b1;
            issue_addr = fifo_ptr;
            issue_last = (fifo_cnt == CNT_ONE);
            addr_d     = fifo_ptr + ADDR_ONE;
            rem_d      = fifo_cnt - CNT_ONE;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (rem_q == CNT_ONE);
          addr_d     = addr_q + ADDR_ONE;
          rem_d      = rem_q - CNT_ONE;
        end
      end
      default: ;
    endcase

    sram_a_d   = issue ? issue_addr : sram_a_q;
    sram_cen_d = !issue;
    last1_d    = issue_last;
    rd2_d      = rd1;
    last2_d    = last1_q;

    // Handshake: a word transfers on a cycle where out_valid && out_ready; the head is held otherwise.
    push = rd2_q;
    pop  = (occ_q != '0) && out_ready;
    wr_d = push ? ((wr_q == LAST_SLOT) ? '0 : wr_q + PTR_ONE_B) : wr_q;
    rd_d = pop  ? ((rd_q == LAST_SLOT) ? '0 : rd_q + PTR_ONE_B) : rd_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  assign head      = (occ_q != '0) ? buf_q[rd_q] : '0;
  assign out_valid = (occ_q != '0);
  assign out_last  = head[EW-1];
  assign out_tag   = head[ID_W +: TAG_W];
  assign out_id    = head[ID_W-1:0];
  assign sram_A    = sram_a_q;
  assign sram_CEN  = sram_cen_q;
  assign busy      = (state_q != IDLE) || (occ_q != '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_neighbor_id_fetch.sv
// Bench for neighbor_id_fetch: FIFO and SRAM models, expected-ID queue filled when
// descriptors are queued and drained as the DUT hands out IDs.
module tb_neighbor_id_fetch;

  localparam int PTR_W     = 12;
  localparam int CNT_W     = 5;
  localparam int ID_W      = 16;
  localparam int TAG_W     = 2;
  localparam int BUF_DEPTH = 4;
  localparam int EW        = ID_W + TAG_W + 1;
  localparam int DW        = TAG_W + PTR_W + CNT_W;

  logic                   clk;
  logic                   reset;
  logic                   fifo_empty;
  logic [PTR_W+CNT_W-1:0] fifo_desc;
  logic [TAG_W-1:0]       fifo_tag;
  logic                   fifo_rinc;
  logic [PTR_W-1:0]       sram_A;
  logic                   sram_CEN;
  logic [ID_W-1:0]        sram_Q;
  logic                   out_valid;
  logic [ID_W-1:0]        out_id;
  logic [TAG_W-1:0]       out_tag;
  logic                   out_last;
  logic                   out_ready;
  logic                   busy;
  logic [1:0]             dbg_state;

  logic [ID_W-1:0]  mem [0:(1<<PTR_W)-1];
  logic [DW-1:0]    desc_q[$];
  logic [EW-1:0]    exp_q[$];
  logic [PTR_W-1:0] addr_log[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  cen_cnt = 0;
  int  out_cnt = 0;
  bit  log_en = 0;
  logic rinc_seen = 1'b0;

  neighbor_id_fetch #(
    .PTR_W(PTR_W), .CNT_W(CNT_W), .ID_W(ID_W), .TAG_W(TAG_W), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .fifo_empty(fifo_empty), .fifo_desc(fifo_desc), .fifo_tag(fifo_tag), .fifo_rinc(fifo_rinc),
    .sram_A(sram_A), .sram_CEN(sram_CEN), .sram_Q(sram_Q),
    .out_valid(out_valid), .out_id(out_id), .out_tag(out_tag), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (!sram_CEN) sram_Q <= mem[sram_A];
  end

  // FIFO model: pop takes effect after the edge that consumed the head
  task automatic drive_fifo();
    fifo_empty = (desc_q.size() == 0);
    if (desc_q.size() != 0) {fifo_tag, fifo_desc} = desc_q[0];
  endtask

  always @(negedge clk) rinc_seen = fifo_rinc;

  always @(posedge clk) begin
    #1;
    if (rinc_seen && desc_q.size() != 0) void'(desc_q.pop_front());
    rinc_seen = 1'b0;
    drive_fifo();
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [PTR_W-1:0] ptr, input logic [CNT_W-1:0] cnt,
                      input logic [TAG_W-1:0] tag);
    logic [PTR_W-1:0] a;
    logic             l;
    desc_q.push_back({tag, ptr, cnt});
    for (int i = 0; i < int'(cnt); i++) begin
      a = ptr + PTR_W'(i);
      l = (i == int'(cnt) - 1);
      exp_q.push_back({l, tag, mem[a]});
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("unexpected_out", {13'd0, out_last, out_tag, out_id}, 32'd0);
        else check("out_word", {13'd0, out_last, out_tag, out_id}, {13'd0, exp_q.pop_front()});
      end
      if (!sram_CEN) begin
        cen_cnt++;
        if (log_en) addr_log.push_back(sram_A);
      end
    end
  end

  task automatic wait_rinc(output bit found);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = fifo_rinc;
    end
    check("rinc_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk);
      #2;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = (desc_q.size() == 0) && (exp_q.size() == 0) && !busy;
    end
    check("drain_done", {31'd0, done}, 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    bit found;
    int cen0, oc0, t0, pops, second_pop, first_last;

    for (int i = 0; i < (1 << PTR_W); i++) mem[i] = ID_W'((i * 40503) ^ 16'h5A5A);
    mem[12'h010] = 16'h00A0;
    mem[12'h011] = 16'h00A1;
    mem[12'h012] = 16'h00A2;
    reset = 1'b1; out_ready = 1'b1; sram_Q = '0;
    fifo_empty = 1'b1; fifo_desc = '0; fifo_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_cen", {31'd0, sram_CEN}, 32'd1);
    check("rst_addr", {20'd0, sram_A}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_id", {16'd0, out_id}, 32'd0);

    // basic latency: pop t0, A at t0+1, IDs at t0+3..t0+5
    send(12'h010, 5'd3, 2'd2);
    wait_rinc(found);
    @(negedge clk);
    check("t1_cen", {31'd0, sram_CEN}, 32'd0);
    check("t1_addr", {20'd0, sram_A}, 32'h010);
    @(negedge clk);
    check("t1_valid_t2", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_t3", {31'd0, out_valid}, 32'd1);
    check("t1_id_t3", {16'd0, out_id}, 32'h00A0);
    check("t1_tag_t3", {30'd0, out_tag}, 32'd2);
    check("t1_last_t3", {31'd0, out_last}, 32'd0);
    @(negedge clk);
    check("t1_valid_t4", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("t1_last_t5", {31'd0, out_last}, 32'd1);
    @(negedge clk);
    check("t1_valid_t6", {31'd0, out_valid}, 32'd0);
    check("t1_busy_t6", {31'd0, busy}, 32'd0);

    // zero-count descriptor is dropped silently
    cen0 = cen_cnt; oc0 = out_cnt;
    send(12'h050, 5'd0, 2'd1);
    send(12'h020, 5'd1, 2'd3);
    wait_idle(60, 0);
    check("t2_cen_pulses", cen_cnt - cen0, 32'd1);
    check("t2_outputs", out_cnt - oc0, 32'd1);

    // address wrap
    addr_log.delete(); log_en = 1;
    send(12'hFFE, 5'd4, 2'd0);
    wait_idle(60, 0);
    log_en = 0;
    check("t3_addr_n", addr_log.size(), 32'd4);
    if (addr_log.size() == 4) begin
      check("t3_a0", {20'd0, addr_log[0]}, 32'hFFE);
      check("t3_a1", {20'd0, addr_log[1]}, 32'hFFF);
      check("t3_a2", {20'd0, addr_log[2]}, 32'h000);
      check("t3_a3", {20'd0, addr_log[3]}, 32'h001);
    end

    // back-pressure from t0+3 for 6 cycles
    cen0 = cen_cnt; oc0 = out_cnt;
    send(12'h100, 5'd8, 2'd1);
    wait_rinc(found);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_id", {16'd0, out_id}, {16'd0, mem[12'h100]});
    end
    check("t4_issued", cen_cnt - cen0, BUF_DEPTH);
    out_ready = 1'b1;
    wait_idle(80, 0);
    check("t4_outputs", out_cnt - oc0, 32'd8);

    // back-to-back descriptors, random ready
    pops = 0; second_pop = -1; first_last = -1;
    send(12'h040, 5'd5, 2'd1);
    send(12'h060, 5'd3, 2'd3);
    for (int k = 0; k < 300 && !(pops == 2 && exp_q.size() == 0); k++) begin
      @(posedge clk);
      #2 out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (fifo_rinc) begin
        pops++;
        if (pops == 2) second_pop = cyc;
      end
      if (out_valid && out_ready && out_last && first_last < 0) first_last = cyc;
    end
    check("t5_pops", pops, 32'd2);
    check("t5_second_pop", second_pop, first_last + 1);
    out_ready = 1'b1;
    wait_idle(60, 0);

    // reset while issuing
    send(12'h200, 5'd10, 2'd2);
    wait_rinc(found);
    t0 = cyc;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_cycle", cyc - t0, 32'd2);
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_cen", {31'd0, sram_CEN}, 32'd1);
    check("t6_state", {30'd0, dbg_state}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    oc0 = out_cnt;
    send(12'h300, 5'd3, 2'd1);
    wait_idle(60, 0);
    check("t6_outputs", out_cnt - oc0, 32'd3);

    // random descriptors with random ready
    for (int d = 0; d < 5; d++) begin
      send(PTR_W'($urandom_range(0, 4095)), CNT_W'($urandom_range(0, 12)), TAG_W'($urandom_range(0, 3)));
    end
    wait_idle(600, 1);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
